instruction_decode_pipe: RTL and testbench
==========================================

INSTRUCTION_DECODE_PIPE -- requirements
Module: instruction_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal range 32..64.
REQ-002 Parameter NREG, default 32, register count; power of two, 2..32; RAW = log2(NREG).
REQ-003 Parameter TEST_INIT, default 1, when 1 reset loads r1=1, r2=2, r3=3, r4=5, else all zero.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 if_valid  in  1  IF/ID holds a real instruction.
REQ-008 if_pc, if_ir  in  XLEN, 32  IF/ID PC and instruction.
REQ-009 flush  in  1  kill instruction in ID (taken branch or jump downstream).
REQ-010 wb_we, wb_memtoreg  in  1  writeback enable and source select.
REQ-011 wb_rd  in  RAW  writeback destination.
REQ-012 wb_mdr, wb_aluout  in  XLEN  writeback data candidates.
REQ-013 stall  out  1  combinational: hold PC and IF/ID this cycle.
REQ-014 ex_valid, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump  out  1  registered ID/EX controls.
REQ-015 ex_aluctr  out  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 beq-cmp, 6 bne-cmp, 7 none.
REQ-016 ex_pc, ex_jt, ex_a, ex_b, ex_md  out  XLEN  PC, jump target, operand A, operand B, store data.
REQ-017 ex_imm  out  16  raw immediate; ex_rd  out  RAW  destination.
REQ-018 illegal  out  1  one-cycle registered pulse for an undecodable valid instruction.

Function
REQ-019 Decode: R-type funct 32/34/36/37/42; lw 35, sw 43, beq 4, bne 5, j 2, addi 8, slti 10 (sign-extended imm); andi 12, ori 13 (zero-extended imm).
REQ-020 R-type/beq/bne: B = rt value, rd = IR[15:11] for R-type, ex_regwrite only for R-type and I-type ALU ops and lw.
REQ-021 I-type ALU and lw: rd = IR[20:16]; sw: ex_rd = IR[20:16], ex_regwrite=0, ex_md = rt value.
REQ-022 ex_jt = {if_pc[XLEN-1:28], IR[25:0], 2'b00}; ex_jump=1 only for j.
REQ-023 r0 reads zero always; writes with wb_rd=0 are discarded.
REQ-024 Write-through bypass: wb_we with wb_rd==rs/rt (nonzero) makes A/B/MD take the writeback value in the same cycle.
REQ-025 Load-use hazard = ex_valid & ex_memread & ex_rd!=0 & (ex_rd==rs, or ex_rd==rt when rt is a source: R-type, beq, bne, sw).
REQ-026 stall = hazard & if_valid & ~flush; while stall is high, the ID/EX register loads a bubble; stall lasts exactly one cycle per hazard.
REQ-027 Bubble: ex_valid=0, all six control bits 0, ex_aluctr=7; data fields don't-care but deterministic (hold).
REQ-028 flush, if_valid=0, or illegal decode each load a bubble; flush has priority over stall and illegal.
REQ-029 illegal pulses one cycle after an unknown opcode/funct is in ID with if_valid=1 and flush=0.
REQ-030 Register file writes on the rising edge; the ID/EX register updates every cycle (no enable).

Reset
REQ-031 rst_n low: all ID/EX outputs 0 except ex_aluctr=7; illegal=0; register file per TEST_INIT.
REQ-032 Reset asserted mid-operation takes effect immediately; the first post-reset edge samples if_ir normally.

Structure
REQ-033 Package id_pkg holds opcode/funct constants, the ALU-op enum, and the bubble constant.
REQ-034 Sub-module reg_file: NREG x XLEN, two read ports, one write port, r0 hardwired, write-through bypass.

Verification
REQ-035 Reset with TEST_INIT=1, decode add r5,r1,r4 -> ex_a=1, ex_b=5, ex_rd=5, ex_aluctr=0, ex_regwrite=1.
REQ-036 lw r6,4(r2), then add r7,r6,r1 -> stall=1 for one cycle, bubble (ex_valid=0), then add issues with A forwarded when wb_rd=6.
REQ-037 wb_we=1, wb_rd=3, wb_aluout=0x55, with or r8,r3,r0 in ID the same cycle -> ex_a=0x55.
REQ-038 ori r9,r0,0xFFFF -> ex_b=0x0000FFFF; addi r9,r0,0xFFFF -> ex_b=0xFFFFFFFF.
REQ-039 flush=1 coincident with a load-use hazard -> stall=0, bubble; opcode 63 -> illegal pulse, bubble.
REQ-040 j 0x100 at pc 0x40000000 -> ex_jump=1, ex_jt=0x40000400; write to r0 -> r0 still reads 0.

Source files
------------

// File: rtl/id_pkg.sv
// ============================================================================
//  Module      : id_pkg
//  Description : Opcode/funct encodings, ALU-op enum and ID/EX control bundle
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_BEQ  = 3'd5,
        ALU_BNE  = 3'd6,
        ALU_NONE = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        logic    memtoreg;
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    branch;
        logic    jump;
        alu_op_e aluctr;
    } ctrl_t;

    localparam ctrl_t C_BUBBLE = '{valid: 1'b0, memtoreg: 1'b0, regwrite: 1'b0,
                                   memread: 1'b0, memwrite: 1'b0, branch: 1'b0,
                                   jump: 1'b0, aluctr: ALU_NONE};

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
//  Module      : reg_file
//  Description : NREG x XLEN register file, 2R/1W, r0 hardwired, write-through
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int RAW       = 5,
    parameter int TEST_INIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  ra1_i,
    input  logic [RAW-1:0]  ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [RAW-1:0]  wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREG];

    function automatic logic [XLEN-1:0] init_val(input int idx);
        if (TEST_INIT == 0) return '0;
        case (idx)
            1:       return XLEN'(1);
            2:       return XLEN'(2);
            3:       return XLEN'(3);
            4:       return XLEN'(5);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= init_val(i);
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Writeback in the same cycle is visible to the reader (write-through).
    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == '0)                  rd1_o = '0;
        else if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
        rd2_o = regs_q[ra2_i];
        if (ra2_i == '0)                  rd2_o = '0;
        else if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
    end

endmodule

`default_nettype wire

// File: rtl/instruction_decode_pipe.sv
// ============================================================================
//  Module      : instruction_decode_pipe
//  Description : ID stage with load-use stall, flush and ID/EX pipeline register
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module instruction_decode_pipe
    import id_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NREG      = 32,
    parameter  int TEST_INIT = 1,
    localparam int RAW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_ir,
    input  logic            flush,
    input  logic            wb_we,
    input  logic            wb_memtoreg,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_mdr,
    input  logic [XLEN-1:0] wb_aluout,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [2:0]      ex_aluctr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_jt,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_md,
    output logic [15:0]     ex_imm,
    output logic [RAW-1:0]  ex_rd,
    output logic            illegal
);

    logic [5:0]      op_w, funct_w;
    logic [RAW-1:0]  rs_w, rt_w, rdf_w;
    logic [XLEN-1:0] rs_val_w, rt_val_w, wb_data_w, imm_ext_w;
    ctrl_t           dec_ctrl_w, ctrl_d, ctrl_q;
    logic            imm_sel_w, imm_zext_w, rt_src_w, known_w;
    logic [RAW-1:0]  dec_rd_w;
    logic            hazard_w, bubble_w, illegal_d, illegal_q;
    logic [XLEN-1:0] pc_q, jt_q, a_q, b_q, md_q;
    logic [15:0]     imm_q;
    logic [RAW-1:0]  rd_q;

    assign op_w      = if_ir[31:26];
    assign funct_w   = if_ir[5:0];
    assign rs_w      = if_ir[21 +: RAW];
    assign rt_w      = if_ir[16 +: RAW];
    assign rdf_w     = if_ir[11 +: RAW];
    assign wb_data_w = wb_memtoreg ? wb_mdr : wb_aluout;
    assign imm_ext_w = imm_zext_w ? {{(XLEN-16){1'b0}}, if_ir[15:0]}
                                  : {{(XLEN-16){if_ir[15]}}, if_ir[15:0]};

    reg_file #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW), .TEST_INIT(TEST_INIT)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs_w),
        .ra2_i (rt_w),
        .rd1_o (rs_val_w),
        .rd2_o (rt_val_w),
        .we_i  (wb_we),
        .wa_i  (wb_rd),
        .wd_i  (wb_data_w)
    );

    always_comb begin
        dec_ctrl_w       = C_BUBBLE;
        dec_ctrl_w.valid = 1'b1;
        imm_sel_w        = 1'b0;
        imm_zext_w       = 1'b0;
        rt_src_w         = 1'b0;
        known_w          = 1'b1;
        dec_rd_w         = '0;
        case (op_w)
            OP_RTYPE: begin
                rt_src_w            = 1'b1;
                dec_rd_w            = rdf_w;
                dec_ctrl_w.regwrite = 1'b1;
                case (funct_w)
                    FN_ADD:  dec_ctrl_w.aluctr = ALU_ADD;
                    FN_SUB:  dec_ctrl_w.aluctr = ALU_SUB;
                    FN_AND:  dec_ctrl_w.aluctr = ALU_AND;
                    FN_OR:   dec_ctrl_w.aluctr = ALU_OR;
                    FN_SLT:  dec_ctrl_w.aluctr = ALU_SLT;
                    default: known_w = 1'b0;
                endcase
            end
            OP_LW: begin
                dec_ctrl_w.memread  = 1'b1;
                dec_ctrl_w.memtoreg = 1'b1;
                dec_ctrl_w.regwrite = 1'b1;
                dec_ctrl_w.aluctr   = ALU_ADD;
                imm_sel_w           = 1'b1;
                dec_rd_w            = rt_w;
            end
            OP_SW: begin
                dec_ctrl_w.memwrite = 1'b1;
                dec_ctrl_w.aluctr   = ALU_ADD;
                imm_sel_w           = 1'b1;
                rt_src_w            = 1'b1;
                dec_rd_w            = rt_w;
            end
            OP_BEQ, OP_BNE: begin
                dec_ctrl_w.branch = 1'b1;
                dec_ctrl_w.aluctr = (op_w == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                rt_src_w          = 1'b1;
            end
            OP_J: dec_ctrl_w.jump = 1'b1;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec_ctrl_w.regwrite = 1'b1;
                imm_sel_w           = 1'b1;
                imm_zext_w          = (op_w == OP_ANDI) || (op_w == OP_ORI);
                dec_rd_w            = rt_w;
                case (op_w)
                    OP_ADDI: dec_ctrl_w.aluctr = ALU_ADD;
                    OP_SLTI: dec_ctrl_w.aluctr = ALU_SLT;
                    OP_ANDI: dec_ctrl_w.aluctr = ALU_AND;
                    default: dec_ctrl_w.aluctr = ALU_OR;
                endcase
            end
            default: known_w = 1'b0;
        endcase
    end

    assign hazard_w = ctrl_q.valid && ctrl_q.memread && (rd_q != '0) &&
                      ((rd_q == rs_w) || (rt_src_w && (rd_q == rt_w)));
    assign stall    = hazard_w && if_valid && !flush;
    assign bubble_w = flush || !if_valid || stall || !known_w;
    assign ctrl_d   = bubble_w ? C_BUBBLE : dec_ctrl_w;
    // A stalled illegal instruction is reported once, when it finally leaves ID.
    assign illegal_d = if_valid && !flush && !stall && !known_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= C_BUBBLE;
            illegal_q <= 1'b0;
            pc_q      <= '0;
            jt_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            md_q      <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            if (!bubble_w) begin
                pc_q  <= if_pc;
                jt_q  <= {if_pc[XLEN-1:28], if_ir[25:0], 2'b00};
                a_q   <= rs_val_w;
                b_q   <= imm_sel_w ? imm_ext_w : rt_val_w;
                md_q  <= rt_val_w;
                imm_q <= if_ir[15:0];
                rd_q  <= dec_rd_w;
            end
        end
    end

    assign ex_valid    = ctrl_q.valid;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_branch   = ctrl_q.branch;
    assign ex_jump     = ctrl_q.jump;
    assign ex_aluctr   = ctrl_q.aluctr;
    assign ex_pc       = pc_q;
    assign ex_jt       = jt_q;
    assign ex_a        = a_q;
    assign ex_b        = b_q;
    assign ex_md       = md_q;
    assign ex_imm      = imm_q;
    assign ex_rd       = rd_q;
    assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode_pipe.sv
// ============================================================================
//  Module      : tb_instruction_decode_pipe
//  Description : Scoreboard bench for the ID stage / ID-EX register
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, flush, wb_we, wb_memtoreg;
    logic [31:0] if_pc, if_ir, wb_mdr, wb_aluout;
    logic [4:0]  wb_rd;
    logic        stall, ex_valid, ex_memtoreg, ex_regwrite, ex_memread;
    logic        ex_memwrite, ex_branch, ex_jump, illegal;
    logic [2:0]  ex_aluctr;
    logic [31:0] ex_pc, ex_jt, ex_a, ex_b, ex_md;
    logic [15:0] ex_imm;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    instruction_decode_pipe #(.XLEN(32), .NREG(32), .TEST_INIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
        .flush(flush), .wb_we(wb_we), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
        .wb_mdr(wb_mdr), .wb_aluout(wb_aluout), .stall(stall), .ex_valid(ex_valid),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_aluctr(ex_aluctr), .ex_pc(ex_pc), .ex_jt(ex_jt), .ex_a(ex_a), .ex_b(ex_b),
        .ex_md(ex_md), .ex_imm(ex_imm), .ex_rd(ex_rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ctl = {valid, memtoreg, regwrite, memread, memwrite, branch, jump, aluctr}
    typedef struct {
        int          tag;
        logic [9:0]  ctl;
        logic        ill;
        bit          chk_data;
        logic [31:0] a, b;
        logic [4:0]  rd;
        bit          chk_md;
        logic [31:0] md;
        bit          chk_jt;
        logic [31:0] jt, pc;
        bit          chk_imm;
        logic [15:0] imm;
    } exp_t;

    exp_t sb[$];

    function automatic logic [9:0] ctl(input logic v, mt, rw, mr, mw, br, jp,
                                       input logic [2:0] alu);
        return {v, mt, rw, mr, mw, br, jp, alu};
    endfunction

    function automatic exp_t e_op(input int tag, input logic [9:0] c,
                                  input logic [31:0] a, b, input logic [4:0] rd);
        exp_t e;
        e = '{tag: tag, ctl: c, ill: 1'b0, chk_data: 1'b1, a: a, b: b, rd: rd,
              chk_md: 1'b0, md: '0, chk_jt: 1'b0, jt: '0, pc: '0, chk_imm: 1'b0, imm: '0};
        return e;
    endfunction

    function automatic exp_t e_bub(input int tag, input logic ill);
        exp_t e;
        e = e_op(tag, 10'b0000000_111, '0, '0, '0);
        e.chk_data = 1'b0;
        e.ill      = ill;
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Scoreboard: one entry is pushed per driven cycle, popped just after the edge.
    always begin
        exp_t e;
        logic [9:0] obs;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {ex_valid, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                   ex_branch, ex_jump, ex_aluctr};
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL ctl[%0d]: got %b required %b", e.tag, obs, e.ctl);
            end
            checks++;
            if (illegal !== e.ill) begin
                errors++;
                $display("FAIL illegal[%0d]: got %b required %b", e.tag, illegal, e.ill);
            end
            if (e.chk_data) begin
                checks++;
                if (ex_a !== e.a || ex_b !== e.b || ex_rd !== e.rd) begin
                    errors++;
                    $display("FAIL data[%0d]: got a=%h b=%h rd=%0d required a=%h b=%h rd=%0d",
                             e.tag, ex_a, ex_b, ex_rd, e.a, e.b, e.rd);
                end
            end
            if (e.chk_md) begin
                checks++;
                if (ex_md !== e.md) begin
                    errors++;
                    $display("FAIL md[%0d]: got %h required %h", e.tag, ex_md, e.md);
                end
            end
            if (e.chk_jt) begin
                checks++;
                if (ex_jt !== e.jt || ex_pc !== e.pc) begin
                    errors++;
                    $display("FAIL jt[%0d]: got jt=%h pc=%h required jt=%h pc=%h",
                             e.tag, ex_jt, ex_pc, e.jt, e.pc);
                end
            end
            if (e.chk_imm) begin
                checks++;
                if (ex_imm !== e.imm) begin
                    errors++;
                    $display("FAIL imm[%0d]: got %h required %h", e.tag, ex_imm, e.imm);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic fl);
        if_valid = v;
        if_ir    = ir;
        flush    = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        if_pc = 32'h0; wb_we = 1'b0; wb_memtoreg = 1'b0; wb_rd = '0;
        wb_mdr = '0; wb_aluout = '0;
        #12;
        checks++;
        if (ex_valid !== 1'b0 || ex_aluctr !== 3'd7 || ex_regwrite !== 1'b0 ||
            ex_memread !== 1'b0 || ex_jump !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got v=%b alu=%0d rw=%b mr=%b j=%b required 0/7/0/0/0",
                     ex_valid, ex_aluctr, ex_regwrite, ex_memread, ex_jump);
        end
        checks++;
        if (ex_a !== 32'h0 || ex_b !== 32'h0 || ex_jt !== 32'h0 || ex_rd !== 5'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h jt=%h rd=%0d ill=%b required zeros",
                     ex_a, ex_b, ex_jt, ex_rd, illegal);
        end
        #11 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_rtype();
        drive(1'b1, rtype(5'd1, 5'd4, 5'd5, 6'd32), 1'b0);
        sb.push_back(e_op(1, ctl(1,0,1,0,0,0,0,3'd0), 32'd1, 32'd5, 5'd5));
        cyc();
        drive(1'b1, rtype(5'd3, 5'd2, 5'd10, 6'd34), 1'b0);
        sb.push_back(e_op(2, ctl(1,0,1,0,0,0,0,3'd1), 32'd3, 32'd2, 5'd10));
        cyc();
        drive(1'b1, rtype(5'd1, 5'd2, 5'd11, 6'd42), 1'b0);
        sb.push_back(e_op(3, ctl(1,0,1,0,0,0,0,3'd4), 32'd1, 32'd2, 5'd11));
        cyc();
    endtask

    task automatic test_immediates();
        exp_t e;
        drive(1'b1, itype(6'd13, 5'd0, 5'd9, 16'hFFFF), 1'b0);
        e = e_op(10, ctl(1,0,1,0,0,0,0,3'd3), 32'h0, 32'h0000FFFF, 5'd9);
        e.chk_imm = 1'b1; e.imm = 16'hFFFF;
        sb.push_back(e);
        cyc();
        drive(1'b1, itype(6'd8, 5'd0, 5'd9, 16'hFFFF), 1'b0);
        sb.push_back(e_op(11, ctl(1,0,1,0,0,0,0,3'd0), 32'h0, 32'hFFFFFFFF, 5'd9));
        cyc();
        drive(1'b1, itype(6'd10, 5'd1, 5'd9, 16'h8000), 1'b0);
        sb.push_back(e_op(12, ctl(1,0,1,0,0,0,0,3'd4), 32'd1, 32'hFFFF8000, 5'd9));
        cyc();
        drive(1'b1, itype(6'd12, 5'd2, 5'd9, 16'h80F0), 1'b0);
        sb.push_back(e_op(13, ctl(1,0,1,0,0,0,0,3'd2), 32'd2, 32'h000080F0, 5'd9));
        cyc();
    endtask

    task automatic test_mem_branch();
        exp_t e;
        drive(1'b1, itype(6'd43, 5'd1, 5'd4, 16'd8), 1'b0);
        e = e_op(20, ctl(1,0,0,0,1,0,0,3'd0), 32'd1, 32'd8, 5'd4);
        e.chk_md = 1'b1; e.md = 32'd5;
        sb.push_back(e);
        cyc();
        drive(1'b1, itype(6'd4, 5'd1, 5'd2, 16'h0010), 1'b0);
        sb.push_back(e_op(21, ctl(1,0,0,0,0,1,0,3'd5), 32'd1, 32'd2, 5'd0));
        cyc();
        drive(1'b1, itype(6'd5, 5'd3, 5'd4, 16'hFFF0), 1'b0);
        sb.push_back(e_op(22, ctl(1,0,0,0,0,1,0,3'd6), 32'd3, 32'd5, 5'd0));
        cyc();
    endtask

    task automatic test_load_use();
        drive(1'b1, itype(6'd35, 5'd2, 5'd6, 16'd4), 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_nostall: got %b required 0", stall);
        end
        sb.push_back(e_op(30, ctl(1,1,1,1,0,0,0,3'd0), 32'd2, 32'd4, 5'd6));
        cyc();
        drive(1'b1, rtype(5'd6, 5'd1, 5'd7, 6'd32), 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall: got %b required 1", stall);
        end
        sb.push_back(e_bub(31, 1'b0));
        cyc();
        wb_we = 1'b1; wb_rd = 5'd6; wb_memtoreg = 1'b1; wb_mdr = 32'h1234; wb_aluout = 32'hBAD;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_release: got %b required 0", stall);
        end
        sb.push_back(e_op(32, ctl(1,0,1,0,0,0,0,3'd0), 32'h1234, 32'd1, 5'd7));
        cyc();
        wb_we = 1'b0; wb_memtoreg = 1'b0;
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_rd = 5'd3; wb_memtoreg = 1'b0; wb_aluout = 32'h55; wb_mdr = 32'hAA;
        drive(1'b1, rtype(5'd3, 5'd0, 5'd8, 6'd37), 1'b0);
        sb.push_back(e_op(40, ctl(1,0,1,0,0,0,0,3'd3), 32'h55, 32'h0, 5'd8));
        cyc();
        wb_we = 1'b0;
        drive(1'b1, rtype(5'd1, 5'd3, 5'd12, 6'd36), 1'b0);
        sb.push_back(e_op(41, ctl(1,0,1,0,0,0,0,3'd2), 32'd1, 32'h55, 5'd12));
        cyc();
    endtask

    task automatic test_flush_illegal();
        drive(1'b1, itype(6'd35, 5'd0, 5'd6, 16'd0), 1'b0);
        sb.push_back(e_op(50, ctl(1,1,1,1,0,0,0,3'd0), 32'd0, 32'd0, 5'd6));
        cyc();
        drive(1'b1, rtype(5'd6, 5'd1, 5'd7, 6'd32), 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b required 0", stall);
        end
        sb.push_back(e_bub(51, 1'b0));
        cyc();
        drive(1'b1, {6'd63, 26'd0}, 1'b0);
        sb.push_back(e_bub(52, 1'b1));
        cyc();
        drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'd1), 1'b0);
        sb.push_back(e_bub(53, 1'b1));
        cyc();
        drive(1'b1, {6'd63, 26'd0}, 1'b1);
        sb.push_back(e_bub(54, 1'b0));
        cyc();
        drive(1'b0, rtype(5'd1, 5'd2, 5'd3, 6'd32), 1'b0);
        sb.push_back(e_bub(55, 1'b0));
        cyc();
    endtask

    task automatic test_jump_r0();
        exp_t e;
        if_pc = 32'h40000000;
        drive(1'b1, {6'd2, 26'h100}, 1'b0);
        e = e_op(60, ctl(1,0,0,0,0,0,1,3'd7), 32'd0, 32'd0, 5'd0);
        e.chk_jt = 1'b1; e.jt = 32'h40000400; e.pc = 32'h40000000;
        sb.push_back(e);
        cyc();
        if_pc = 32'h0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_memtoreg = 1'b0; wb_aluout = 32'hDEAD;
        drive(1'b1, rtype(5'd0, 5'd0, 5'd13, 6'd32), 1'b0);
        sb.push_back(e_op(61, ctl(1,0,1,0,0,0,0,3'd0), 32'd0, 32'd0, 5'd13));
        cyc();
        wb_we = 1'b0;
        drive(1'b1, rtype(5'd0, 5'd1, 5'd13, 6'd32), 1'b0);
        sb.push_back(e_op(62, ctl(1,0,1,0,0,0,0,3'd0), 32'd0, 32'd1, 5'd13));
        cyc();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, rtype(5'd1, 5'd2, 5'd14, 6'd32), 1'b0);
        sb.push_back(e_op(70, ctl(1,0,1,0,0,0,0,3'd0), 32'd1, 32'd2, 5'd14));
        cyc();
        drive(1'b1, rtype(5'd4, 5'd1, 5'd15, 6'd34), 1'b0);
        sb.push_back(e_op(71, ctl(1,0,1,0,0,0,0,3'd1), 32'd5, 32'd1, 5'd15));
        cyc();
        drive(1'b0, rtype(5'd4, 5'd2, 5'd16, 6'd36), 1'b0);
        sb.push_back(e_bub(72, 1'b0));
        cyc();
        drive(1'b1, rtype(5'd4, 5'd2, 5'd16, 6'd36), 1'b0);
        sb.push_back(e_op(73, ctl(1,0,1,0,0,0,0,3'd2), 32'd5, 32'd2, 5'd16));
        cyc();
    endtask

    task automatic test_async_reset();
        drive(1'b1, rtype(5'd1, 5'd4, 5'd5, 6'd32), 1'b0);
        sb.push_back(e_op(80, ctl(1,0,1,0,0,0,0,3'd0), 32'd1, 32'd5, 5'd5));
        cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_aluctr !== 3'd7 || ex_a !== 32'h0 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b alu=%0d a=%h rd=%0d required 0/7/0/0",
                     ex_valid, ex_aluctr, ex_a, ex_rd);
        end
        cyc();
        #2 rst_n = 1'b1;
        // r3 was overwritten with 0x55 earlier; reset must restore it to 3.
        drive(1'b1, rtype(5'd3, 5'd1, 5'd5, 6'd32), 1'b0);
        sb.push_back(e_op(81, ctl(1,0,1,0,0,0,0,3'd0), 32'd3, 32'd1, 5'd5));
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_immediates();
        test_mem_branch();
        test_load_use();
        test_bypass();
        test_flush_illegal();
        test_jump_r0();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
